rc5_key_sched_ctrl: RTL and testbench



---
 rtl/rc5_key_sched_ctrl.sv | 96 +++++++++
 tb/tb_rc5_key_sched_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_sched_ctrl.sv
// rc5_key_sched_ctrl: RC5 key schedule sequencer owning the S-RAM and L-RAM ports
module rc5_key_sched_ctrl #(
   parameter int W = 32,
   parameter int C = 4,
   parameter int T = 26,
   parameter logic [W-1:0] P = 32'hB7E15163,
   parameter logic [W-1:0] Q = 32'h9E3779B9,
   localparam int C_LENGTH = $clog2(C),
   localparam int T_LENGTH = $clog2(T),
   localparam int CNT_LENGTH = (C_LENGTH > T_LENGTH) ? C_LENGTH : T_LENGTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
   input  logic                iKey_valid,
   input  logic [W-1:0]        iKey_word,
   output logic                oKey_ready,
   output logic                oMixStart,
   input  logic                iMixDone,
   input  logic [T_LENGTH-1:0] iMix_S_addr,
   input  logic [W-1:0]        iMix_S_data,
   input  logic                iMix_S_we,
   input  logic [C_LENGTH-1:0] iMix_L_addr,
   input  logic [W-1:0]        iMix_L_data,
   input  logic                iMix_L_we,
   input  logic [T_LENGTH-1:0] iEnc_S_addr,
   output logic [T_LENGTH-1:0] oS_addr,
   output logic [W-1:0]        oS_data,
   output logic                oS_we,
   output logic [C_LENGTH-1:0] oL_addr,
   output logic [W-1:0]        oL_data,
   output logic                oL_we,
   output logic                oBusy,
   output logic                oReady
);

   typedef enum logic [2:0] {IDLE = 3'd0, LOAD_L = 3'd1, INIT_S = 3'd2, MIX = 3'd3, READY = 3'd4} state_t;

   state_t state;
   logic [CNT_LENGTH-1:0] rCnt;
   logic [W-1:0] rSval;

   // Schedule sequencing: key load, S table fill, mixer run, then hand-off to the encryptor
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rCnt  <= '0;
         rSval <= P;
      end else begin
         case (state)
            IDLE: if (iStart) begin
               state <= LOAD_L;
               rCnt  <= '0;
            end
            LOAD_L: if (iKey_valid) begin
               if (rCnt == CNT_LENGTH'(C - 1)) begin
                  state <= INIT_S;
                  rCnt  <= '0;
                  rSval <= P;
               end else rCnt <= rCnt + CNT_LENGTH'(1);
            end
            INIT_S: begin
               rSval <= rSval + Q;
               if (rCnt == CNT_LENGTH'(T - 1)) begin
                  state <= MIX;
                  rCnt  <= '0;
               end else rCnt <= rCnt + CNT_LENGTH'(1);
            end
            MIX: if (iMixDone) state <= READY;
            READY: if (iStart) begin
               state <= LOAD_L;
               rCnt  <= '0;
            end
            default: begin
               state <= IDLE;
               rCnt  <= '0;
            end
         endcase
      end
   end

   // Port ownership: our own writers in LOAD_L/INIT_S, mixer pass-through in MIX, encryptor reads in READY
   always_comb begin
      oKey_ready = state == LOAD_L;
      oMixStart  = state == MIX;
      oReady     = state == READY;
      oBusy      = state == LOAD_L || state == INIT_S || state == MIX;
      oS_addr    = state == INIT_S ? rCnt[T_LENGTH-1:0] : state == MIX ? iMix_S_addr : state == READY ? iEnc_S_addr : '0;
      oS_data    = state == INIT_S ? rSval : state == MIX ? iMix_S_data : '0;
      oS_we      = state == INIT_S || (state == MIX && iMix_S_we);
      oL_addr    = state == LOAD_L ? rCnt[C_LENGTH-1:0] : state == MIX ? iMix_L_addr : '0;
      oL_data    = (state == LOAD_L && iKey_valid) ? iKey_word : state == MIX ? iMix_L_data : '0;
      oL_we      = (state == LOAD_L && iKey_valid) || (state == MIX && iMix_L_we);
   end

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// tb_rc5_key_sched_ctrl: directed-vector bench for the RC5 key schedule controller
module tb_rc5_key_sched_ctrl;
   localparam int W = 32;
   localparam int C = 4;
   localparam int T = 26;
   localparam logic [W-1:0] P = 32'hB7E15163;
   localparam logic [W-1:0] Q = 32'h9E3779B9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic iStart = 1'b0;
   logic iKey_valid = 1'b0;
   logic [W-1:0] iKey_word = '0;
   logic iMixDone = 1'b0;
   logic [4:0] iMix_S_addr = '0;
   logic [W-1:0] iMix_S_data = '0;
   logic iMix_S_we = 1'b0;
   logic [1:0] iMix_L_addr = '0;
   logic [W-1:0] iMix_L_data = '0;
   logic iMix_L_we = 1'b0;
   logic [4:0] iEnc_S_addr = '0;
   logic oKey_ready, oMixStart, oS_we, oL_we, oBusy, oReady;
   logic [4:0] oS_addr;
   logic [1:0] oL_addr;
   logic [W-1:0] oS_data, oL_data;
   logic [76:0] allOut;

   int vectors = 0;
   int miscompares = 0;

   rc5_key_sched_ctrl #(.W(W), .C(C), .T(T), .P(P), .Q(Q)) dut (
      .clk(clk), .rst(rst), .iStart(iStart),
      .iKey_valid(iKey_valid), .iKey_word(iKey_word), .oKey_ready(oKey_ready),
      .oMixStart(oMixStart), .iMixDone(iMixDone),
      .iMix_S_addr(iMix_S_addr), .iMix_S_data(iMix_S_data), .iMix_S_we(iMix_S_we),
      .iMix_L_addr(iMix_L_addr), .iMix_L_data(iMix_L_data), .iMix_L_we(iMix_L_we),
      .iEnc_S_addr(iEnc_S_addr),
      .oS_addr(oS_addr), .oS_data(oS_data), .oS_we(oS_we),
      .oL_addr(oL_addr), .oL_data(oL_data), .oL_we(oL_we),
      .oBusy(oBusy), .oReady(oReady)
   );

   assign allOut = {oKey_ready, oMixStart, oS_we, oS_addr, oS_data, oL_we, oL_addr, oL_data, oBusy, oReady};

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] sConst [3];
      logic [W-1:0] s;
      logic [6:0] pat;
      int n;
      int nW;
      sConst[0] = 32'hB7E15163;
      sConst[1] = 32'h5618CB1C;
      sConst[2] = 32'hF45044D5;
      pat = 7'b1011001;

      rst = 1'b1;
      iStart = 1'b1;
      step;
      step;
      #1 checkVal("rst_outs", allOut, 0);
      iStart = 1'b0;
      rst = 1'b0;
      step;
      #1 checkVal("idle_outs", allOut, 0);

      iStart = 1'b1;
      step;
      iStart = 1'b0;
      for (int i = 0; i < C; i++) begin
         iKey_valid = 1'b1;
         iKey_word = 32'h11111111 * (i + 1);
         #1;
         checkVal("load_ready", oKey_ready, 1);
         checkVal("load_busy", oBusy, 1);
         checkVal("load_we", oL_we, 1);
         checkVal("load_addr", oL_addr, i);
         checkVal("load_data", oL_data, 32'h11111111 * (i + 1));
         checkVal("load_s_we", oS_we, 0);
         step;
      end
      iKey_valid = 1'b0;

      s = P;
      for (int i = 0; i < T; i++) begin
         iStart = (i == 5);
         #1;
         checkVal("init_key_ready", oKey_ready, 0);
         checkVal("init_s_we", oS_we, 1);
         checkVal("init_s_addr", oS_addr, i);
         checkVal("init_s_data", oS_data, s);
         if (i < 3) checkVal("init_s_const", oS_data, sConst[i]);
         checkVal("init_mixstart", oMixStart, 0);
         s = s + Q;
         step;
      end
      iStart = 1'b0;
      #1;
      checkVal("mix_start", oMixStart, 1);
      checkVal("mix_busy", oBusy, 1);
      checkVal("mix_s_we_idle", oS_we, 0);
      checkVal("mix_ready", oReady, 0);

      iMix_S_addr = 5'd7;
      iMix_S_data = 32'hDEADBEEF;
      iMix_S_we = 1'b1;
      iMix_L_addr = 2'd2;
      iMix_L_data = 32'hCAFEF00D;
      iMix_L_we = 1'b1;
      #1;
      checkVal("mix_s_addr", oS_addr, 7);
      checkVal("mix_s_data", oS_data, 32'hDEADBEEF);
      checkVal("mix_s_we", oS_we, 1);
      checkVal("mix_l_addr", oL_addr, 2);
      checkVal("mix_l_data", oL_data, 32'hCAFEF00D);
      checkVal("mix_l_we", oL_we, 1);
      step;
      iMixDone = 1'b1;
      iMix_S_addr = 5'd25;
      iMix_S_data = 32'h12345678;
      #1;
      checkVal("done_s_we", oS_we, 1);
      checkVal("done_s_addr", oS_addr, 25);
      checkVal("done_s_data", oS_data, 32'h12345678);
      checkVal("done_mixstart", oMixStart, 1);
      step;
      iMixDone = 1'b0;
      iEnc_S_addr = 5'd5;
      #1;
      checkVal("ready_ready", oReady, 1);
      checkVal("ready_mixstart", oMixStart, 0);
      checkVal("ready_busy", oBusy, 0);
      checkVal("ready_s_addr", oS_addr, 5);
      checkVal("ready_s_we", oS_we, 0);
      checkVal("ready_s_data", oS_data, 0);
      checkVal("ready_l_we", oL_we, 0);

      iStart = 1'b1;
      step;
      iStart = 1'b0;
      iMix_S_we = 1'b0;
      iMix_L_we = 1'b0;
      iMix_S_addr = '0;
      iMix_S_data = '0;
      iMix_L_addr = '0;
      iMix_L_data = '0;
      #1;
      checkVal("rekey_ready", oReady, 0);
      checkVal("rekey_key_ready", oKey_ready, 1);
      checkVal("rekey_busy", oBusy, 1);

      n = 0;
      nW = 0;
      for (int j = 0; j < 7; j++) begin
         iKey_valid = pat[j];
         iKey_word = 32'hA0A00000 + j;
         #1;
         checkVal("bp_we", oL_we, pat[j]);
         nW += int'(oL_we);
         if (pat[j]) begin
            checkVal("bp_addr", oL_addr, n);
            checkVal("bp_data", oL_data, 32'hA0A00000 + j);
            n++;
         end else checkVal("bp_gap_data", oL_data, 0);
         step;
      end
      iKey_valid = 1'b0;
      checkVal("bp_count", nW, 4);

      for (int i = 0; i <= 10; i++) begin
         #1;
         checkVal("abort_s_we", oS_we, 1);
         checkVal("abort_s_addr", oS_addr, i);
         if (i == 10) rst = 1'b1;
         step;
      end
      #1 checkVal("abort_outs", allOut, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         #1 checkVal("post_abort_outs", allOut, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
